// File: rtl/meas_pkg.sv
// Shared definitions for the measurement datapath:
// counting modes, packer FSM encoding, default widths.
package meas_pkg;

  localparam int W_DEF = 24;

  localparam logic MODE_ADC = 1'b0;
  localparam logic MODE_AVK = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_CALC  = 2'd2,
    S_PUSH  = 2'd3
  } pack_state_e;

endpackage

// File: rtl/sample_queue.sv
// Small synchronous staging FIFO for packed samples.
// Pointers carry a wrap bit so full/empty need no counter.
module sample_queue
  import meas_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int QDEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(QDEPTH);

  logic [W-1:0] mem_q [QDEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;
  logic         do_push;
  logic         do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                   (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = mem_q[rd_q[AW-1:0]];

  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // pointer next-state: flush empties, else advance on push/pop
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
    end
  end

  // pointer registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // storage write
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/count_sample_packer.sv
// Turns counter totals into 24-bit samples and drains them
// into the measurement FIFO, counting back-pressure drops.
module count_sample_packer
  import meas_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int QDEPTH = 2,
  parameter int DROPW  = 8
) (
  input  logic             clk_12mhz,
  input  logic             rst_sync,
  input  logic             count_mode,
  input  logic [W-1:0]     count_p,
  input  logic [W-1:0]     count_m,
  input  logic             rising_edge,
  input  logic             falling_edge,
  input  logic             fifo_full,
  input  logic             fifo_level_reset,
  input  logic             drop_clr,
  output logic [W-1:0]     count,
  output logic             fifo_wr_en,
  output logic [DROPW-1:0] drop_cnt,
  output logic             underflow
);

  pack_state_e      state_q, state_d;
  logic [W-1:0]     op_a_q, op_a_d;
  logic [W-1:0]     op_b_q, op_b_d;
  logic             mode_q, mode_d;
  logic [W-1:0]     sample_q, sample_d;
  logic [W-1:0]     count_q, count_d;
  logic             wr_q, wr_d;
  logic [DROPW-1:0] drop_q, drop_d;
  logic             uf_q, uf_d;

  logic             uf_set;
  logic             push_req;
  logic             can_drain;
  logic             pop;
  logic             bypass;
  logic             q_push;
  logic             drop_ev;
  logic [W-1:0]     q_head;
  logic             q_full;
  logic             q_empty;

  localparam logic [DROPW-1:0] DROP_ONE = {{(DROPW-1){1'b0}}, 1'b1};

  sample_queue #(
    .W      (W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk_i   (clk_12mhz),
    .rst_i   (rst_sync),
    .flush_i (fifo_level_reset),
    .push_i  (q_push),
    .data_i  (sample_q),
    .pop_i   (pop),
    .head_o  (q_head),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // capture/compute FSM next state
  always_comb begin
    state_d  = state_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    mode_d   = mode_q;
    sample_d = sample_q;
    uf_set   = 1'b0;
    push_req = 1'b0;
    if (fifo_level_reset) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (count_mode == MODE_ADC) begin
            if (falling_edge) begin
              op_a_d  = count_p;
              op_b_d  = '0;
              mode_d  = MODE_ADC;
              state_d = S_CALC;
            end
          end else if (rising_edge) begin
            mode_d  = MODE_AVK;
            state_d = S_ARMED;
          end
        end
        S_ARMED: begin
          if (count_mode != mode_q) begin
            state_d = S_IDLE;
          end else if (falling_edge) begin
            op_a_d  = count_p;
            op_b_d  = count_m;
            state_d = S_CALC;
          end
        end
        S_CALC: begin
          if (mode_q == MODE_ADC) begin
            sample_d = op_a_q;
          end else if (op_b_q > op_a_q) begin
            sample_d = '0;
            uf_set   = 1'b1;
          end else begin
            sample_d = op_a_q - op_b_q;
          end
          state_d = S_PUSH;
        end
        S_PUSH: begin
          push_req = 1'b1;
          if (count_mode == MODE_AVK && rising_edge) begin
            mode_d  = MODE_AVK;
            state_d = S_ARMED;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // drain/enqueue steering; an empty queue is bypassed
  always_comb begin
    can_drain = !fifo_full && !fifo_level_reset;
    pop       = can_drain && !q_empty;
    bypass    = can_drain && q_empty && push_req;
    q_push    = push_req && !bypass && !q_full;
    drop_ev   = push_req && !bypass && q_full;
    wr_d      = pop || bypass;
    count_d   = count_q;
    if (pop)         count_d = q_head;
    else if (bypass) count_d = sample_q;
  end

  // drop counter and sticky underflow
  always_comb begin
    drop_d = drop_q;
    if (drop_clr) begin
      drop_d = drop_ev ? DROP_ONE : '0;
    end else if (drop_ev && drop_q != '1) begin
      drop_d = drop_q + 1'b1;
    end
    uf_d = uf_q;
    if (drop_clr) uf_d = 1'b0;
    if (uf_set)   uf_d = 1'b1;
  end

  // state registers
  always_ff @(posedge clk_12mhz) begin
    if (rst_sync) begin
      state_q  <= S_IDLE;
      op_a_q   <= '0;
      op_b_q   <= '0;
      mode_q   <= MODE_ADC;
      sample_q <= '0;
      count_q  <= '0;
      wr_q     <= 1'b0;
      drop_q   <= '0;
      uf_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      mode_q   <= mode_d;
      sample_q <= sample_d;
      count_q  <= count_d;
      wr_q     <= wr_d;
      drop_q   <= drop_d;
      uf_q     <= uf_d;
    end
  end

  assign count      = count_q;
  assign fifo_wr_en = wr_q;
  assign drop_cnt   = drop_q;
  assign underflow  = uf_q;

endmodule

// File: tb/tb_count_sample_packer.sv
// Scoreboard bench for count_sample_packer: a queue model
// predicts every FIFO write; a monitor checks each one.
module tb_count_sample_packer;

  localparam int W  = 24;
  localparam int QD = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_sync;
  logic          count_mode;
  logic [W-1:0]  count_p;
  logic [W-1:0]  count_m;
  logic          rising_edge;
  logic          falling_edge;
  logic          fifo_full;
  logic          fifo_level_reset;
  logic          drop_clr;
  logic [W-1:0]  count;
  logic          fifo_wr_en;
  logic [DW-1:0] drop_cnt;
  logic          underflow;

  count_sample_packer #(
    .W      (W),
    .QDEPTH (QD),
    .DROPW  (DW)
  ) dut (
    .clk_12mhz        (clk),
    .rst_sync         (rst_sync),
    .count_mode       (count_mode),
    .count_p          (count_p),
    .count_m          (count_m),
    .rising_edge      (rising_edge),
    .falling_edge     (falling_edge),
    .fifo_full        (fifo_full),
    .fifo_level_reset (fifo_level_reset),
    .drop_clr         (drop_clr),
    .count            (count),
    .fifo_wr_en       (fifo_wr_en),
    .drop_cnt         (drop_cnt),
    .underflow        (underflow)
  );

  typedef struct {
    logic [W-1:0] val;
    int           cyc;
  } wr_t;

  typedef struct {
    logic [W-1:0] val;
    logic         uf;
    int           pcyc;
  } pend_t;

  int compared   = 0;
  int mismatched = 0;

  wr_t          exp_q[$];
  pend_t        pend[$];
  logic [W-1:0] stq[$];
  logic [W-1:0] wr_log[$];

  int           cyc    = 0;
  int           m_drop = 0;
  logic         m_uf   = 1'b0;
  int           m_n0;
  bit           m_dev;
  bit           m_can;
  bit           m_ufs;
  pend_t        m_e;
  logic [W-1:0] m_tmp;
  wr_t          mo;

  logic         acc     = 1'b0;
  logic [W-1:0] acc_val = '0;
  logic         acc_uf  = 1'b0;
  bit           rnd_full = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // reference model: accepted trigger -> sample due two edges later;
  // staging queue of QD entries drained whenever FIFO not full
  always @(posedge clk) begin
    cyc++;
    if (rst_sync) begin
      stq.delete();
      pend.delete();
      exp_q.delete();
      m_drop = 0;
      m_uf   = 1'b0;
    end else begin
      m_dev = 1'b0;
      m_ufs = 1'b0;
      if (fifo_level_reset) begin
        stq.delete();
        pend.delete();
      end else begin
        m_can = !fifo_full;
        m_n0  = stq.size();
        if (m_can && m_n0 > 0) begin
          m_tmp = stq.pop_front();
          exp_q.push_back('{m_tmp, cyc});
        end
        if (pend.size() > 0 && pend[0].pcyc - 1 == cyc && pend[0].uf)
          m_ufs = 1'b1;
        if (pend.size() > 0 && pend[0].pcyc == cyc) begin
          m_e = pend.pop_front();
          if (m_n0 == 0 && m_can) exp_q.push_back('{m_e.val, cyc});
          else if (m_n0 == QD)    m_dev = 1'b1;
          else                    stq.push_back(m_e.val);
        end
      end
      if (drop_clr) begin
        m_drop = m_dev ? 1 : 0;
        m_uf   = 1'b0;
      end else if (m_dev && m_drop < 255) begin
        m_drop++;
      end
      if (m_ufs) m_uf = 1'b1;
      if (acc && !fifo_level_reset)
        pend.push_back('{acc_val, acc_uf, cyc + 2});
    end
  end

  // monitor: every write must match the oldest predicted write
  always @(negedge clk) begin
    if (fifo_wr_en) begin
      wr_log.push_back(count);
      if (exp_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_write: got 0x%0h expected none", count);
      end else begin
        mo = exp_q.pop_front();
        chk("write_cycle", 32'(cyc), 32'(mo.cyc));
        chk("write_data", 32'(count), 32'(mo.val));
      end
    end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      mo = exp_q.pop_front();
      compared++;
      mismatched++;
      $display("FAIL missing_write: got none expected 0x%0h", mo.val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_full) fifo_full = ($urandom_range(0, 9) < 3);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic trig0(input logic [W-1:0] p, input int gap);
    count_mode   = 1'b0;
    count_p      = p;
    falling_edge = 1'b1;
    acc          = 1'b1;
    acc_val      = p;
    acc_uf       = 1'b0;
    tick();
    falling_edge = 1'b0;
    acc          = 1'b0;
    idle(gap);
  endtask

  task automatic trig1(input logic [W-1:0] p, input logic [W-1:0] m,
                       input int gap);
    count_mode   = 1'b1;
    rising_edge  = 1'b1;
    tick();
    rising_edge  = 1'b0;
    count_p      = p;
    count_m      = m;
    falling_edge = 1'b1;
    acc          = 1'b1;
    acc_val      = (m > p) ? '0 : p - m;
    acc_uf       = (m > p);
    tick();
    falling_edge = 1'b0;
    acc          = 1'b0;
    idle(gap);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [W-1:0] p;
    logic [W-1:0] m;
    rst_sync         = 1'b1;
    count_mode       = 1'b0;
    count_p          = '0;
    count_m          = '0;
    rising_edge      = 1'b0;
    falling_edge     = 1'b0;
    fifo_full        = 1'b0;
    fifo_level_reset = 1'b0;
    drop_clr         = 1'b0;
    idle(2);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_wr_en", 32'(fifo_wr_en), 32'h0);
    chk("rst_drop", 32'(drop_cnt), 32'h0);
    chk("rst_uf", 32'(underflow), 32'h0);
    rst_sync = 1'b0;

    // mode 0 latency
    n = wr_log.size();
    trig0(24'h000123, 0);
    tick();
    chk("t1_early", 32'(fifo_wr_en), 32'h0);
    tick();
    chk("t1_wr_t3", 32'(fifo_wr_en), 32'h1);
    chk("t1_count", 32'(count), 32'h000123);
    idle(2);
    chk("t1_nwr", 32'(wr_log.size() - n), 32'h1);

    // mode 1 difference and clamp
    n = wr_log.size();
    trig1(24'h001000, 24'h000400, 4);
    chk("t2_nwr", 32'(wr_log.size() - n), 32'h1);
    chk("t2_diff", 32'(wr_log[$]), 32'h000C00);
    chk("t2_uf0", 32'(underflow), 32'h0);
    trig1(24'h000100, 24'h000500, 4);
    chk("t2_clamp", 32'(wr_log[$]), 32'h0);
    chk("t2_uf1", 32'(underflow), 32'h1);

    // back-pressure: 2 queued, 3 dropped
    fifo_full = 1'b1;
    n = wr_log.size();
    for (int i = 0; i < 5; i++) trig0(24'h0A0001 + 24'(i), 2);
    chk("t3_drop", 32'(drop_cnt), 32'd3);
    chk("t3_nowr", 32'(wr_log.size() - n), 32'h0);
    fifo_full = 1'b0;
    tick();
    chk("t3_wr0", 32'(fifo_wr_en), 32'h1);
    chk("t3_d0", 32'(count), 32'h0A0001);
    tick();
    chk("t3_wr1", 32'(fifo_wr_en), 32'h1);
    chk("t3_d1", 32'(count), 32'h0A0002);
    tick();
    chk("t3_wr2", 32'(fifo_wr_en), 32'h0);

    // flush with 2 queued
    fifo_full = 1'b1;
    trig0(24'h0000B1, 2);
    trig0(24'h0000B2, 2);
    n = wr_log.size();
    fifo_level_reset = 1'b1;
    fifo_full        = 1'b0;
    tick();
    fifo_level_reset = 1'b0;
    idle(3);
    chk("t4_nowr", 32'(wr_log.size() - n), 32'h0);
    chk("t4_drop", 32'(drop_cnt), 32'd3);
    trig0(24'h0000B3, 0);
    tick();
    tick();
    chk("t4_wr_t3", 32'(fifo_wr_en), 32'h1);
    chk("t4_count", 32'(count), 32'h0000B3);
    idle(2);

    // drop saturation and clear
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("t5_clr", 32'(drop_cnt), 32'h0);
    chk("t5_uf_clr", 32'(underflow), 32'h0);
    fifo_full = 1'b1;
    for (int i = 0; i < 302; i++) trig0(24'(i + 1), 2);
    chk("t5_sat", 32'(drop_cnt), 32'd255);
    trig0(24'h0000D1, 0);
    tick();
    drop_clr = 1'b1;
    tick();
    drop_clr = 1'b0;
    chk("t5_clr_drop", 32'(drop_cnt), 32'd1);
    idle(1);

    // reset while in S_CALC with one sample queued
    fifo_full = 1'b0;
    idle(3);
    trig1(24'h000001, 24'h000002, 2);
    trig0(24'h00005A, 2);
    fifo_full = 1'b1;
    trig0(24'h0000C1, 2);
    n = wr_log.size();
    trig0(24'h0000C2, 0);
    rst_sync  = 1'b1;
    fifo_full = 1'b0;
    tick();
    chk("t6_wr", 32'(fifo_wr_en), 32'h0);
    chk("t6_count", 32'(count), 32'h0);
    chk("t6_drop", 32'(drop_cnt), 32'h0);
    chk("t6_uf", 32'(underflow), 32'h0);
    rst_sync = 1'b0;
    idle(5);
    chk("t6_nowr", 32'(wr_log.size() - n), 32'h0);

    // mode change while armed drops back to idle
    count_mode  = 1'b1;
    rising_edge = 1'b1;
    tick();
    rising_edge = 1'b0;
    count_mode  = 1'b0;
    tick();
    count_mode   = 1'b1;
    count_p      = 24'h000777;
    falling_edge = 1'b1;
    tick();
    falling_edge = 1'b0;
    idle(4);
    chk("t6_mode_nowr", 32'(wr_log.size() - n), 32'h0);

    // randomized traffic with random back-pressure
    rnd_full = 1'b1;
    repeat (150) begin
      p = 24'($urandom);
      m = 24'($urandom);
      if ($urandom_range(0, 1) == 0) trig0(p, $urandom_range(2, 5));
      else                           trig1(p, m, $urandom_range(2, 5));
    end
    rnd_full  = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && stq.size() == 0 && pend.size() == 0)
        break;
      tick();
    end
    idle(2);
    chk("rnd_drain", 32'(exp_q.size() + stq.size() + pend.size()), 32'h0);
    chk("rnd_drop", 32'(drop_cnt), 32'(m_drop));
    chk("rnd_uf", 32'(underflow), 32'(m_uf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
